// File: rtl/studioii_keypad_if.sv
// Keypad bus between the PS/2 feed / CPU select latch and the Studio II pad logic.
// Master drives key events and the select write; slave returns flags and maps.
interface studioii_keypad_if;
    logic [10:0] ps2_key;
    logic [3:0]  key_sel;
    logic        key_sel_we;
    logic        ef3;
    logic        ef4;
    logic [9:0]  pad1_keys;
    logic [9:0]  pad2_keys;

    modport master (
        output ps2_key,
        output key_sel,
        output key_sel_we,
        input  ef3,
        input  ef4,
        input  pad1_keys,
        input  pad2_keys
    );

    modport slave (
        input  ps2_key,
        input  key_sel,
        input  key_sel_we,
        output ef3,
        output ef4,
        output pad1_keys,
        output pad2_keys
    );
endinterface

// File: rtl/studioii_keypad.sv
// PS/2 set-2 key words to RCA Studio II dual 10-key pads with EF3/EF4 flags.
// Optional idle-clear of stuck keys: define KEYPAD_WATCHDOG_EN.
module studioii_keypad #(
    parameter int unsigned WDT_CYCLES = 48_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    studioii_keypad_if.slave  kp
);
    logic       stb_q;
    logic       primed_q;
    logic [3:0] sel_q, sel_d;
    logic [9:0] pad1_q, pad1_d;
    logic [9:0] pad2_q, pad2_d;
    logic       ef3_q, ef4_q;

    logic       evt;
    logic       hit1, hit2;
    logic [3:0] idx;

    assign evt = primed_q && (kp.ps2_key[10] != stb_q);

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = 4'd0;
        unique case (kp.ps2_key[7:0])
            8'h45: begin hit1 = 1'b1; idx = 4'd0; end
            8'h16: begin hit1 = 1'b1; idx = 4'd1; end
            8'h1E: begin hit1 = 1'b1; idx = 4'd2; end
            8'h26: begin hit1 = 1'b1; idx = 4'd3; end
            8'h25: begin hit1 = 1'b1; idx = 4'd4; end
            8'h2E: begin hit1 = 1'b1; idx = 4'd5; end
            8'h36: begin hit1 = 1'b1; idx = 4'd6; end
            8'h3D: begin hit1 = 1'b1; idx = 4'd7; end
            8'h3E: begin hit1 = 1'b1; idx = 4'd8; end
            8'h46: begin hit1 = 1'b1; idx = 4'd9; end
            8'h70: begin hit2 = 1'b1; idx = 4'd0; end
            8'h69: begin hit2 = 1'b1; idx = 4'd1; end
            8'h72: begin hit2 = 1'b1; idx = 4'd2; end
            8'h7A: begin hit2 = 1'b1; idx = 4'd3; end
            8'h6B: begin hit2 = 1'b1; idx = 4'd4; end
            8'h73: begin hit2 = 1'b1; idx = 4'd5; end
            8'h74: begin hit2 = 1'b1; idx = 4'd6; end
            8'h6C: begin hit2 = 1'b1; idx = 4'd7; end
            8'h75: begin hit2 = 1'b1; idx = 4'd8; end
            8'h7D: begin hit2 = 1'b1; idx = 4'd9; end
            default: ;
        endcase
    end

`ifdef KEYPAD_WATCHDOG_EN
    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

    logic [31:0] wdt_q, wdt_d;
    logic        wdt_fire;

    // A fresh event wins over a same-edge timeout.
    assign wdt_fire = (wdt_q == WDT_LAST) && (|{pad1_q, pad2_q}) && !evt;

    always_comb begin
        wdt_d = wdt_q;
        if (evt)
            wdt_d = 32'd0;
        else if (wdt_q != WDT_LAST)
            wdt_d = wdt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wdt_q <= 32'd0;
        else
            wdt_q <= wdt_d;
    end
`endif

    always_comb begin
        pad1_d = pad1_q;
        pad2_d = pad2_q;
        // Extended codes are cursor keys sharing numpad codes.
        if (evt && !kp.ps2_key[8]) begin
            if (hit1) pad1_d[idx] = kp.ps2_key[9];
            if (hit2) pad2_d[idx] = kp.ps2_key[9];
        end
`ifdef KEYPAD_WATCHDOG_EN
        if (wdt_fire) begin
            pad1_d = 10'd0;
            pad2_d = 10'd0;
        end
`endif
    end

    assign sel_d = kp.key_sel_we ? kp.key_sel : sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stb_q    <= 1'b0;
            primed_q <= 1'b0;
            sel_q    <= 4'd0;
            pad1_q   <= 10'd0;
            pad2_q   <= 10'd0;
            ef3_q    <= 1'b0;
            ef4_q    <= 1'b0;
        end else begin
            stb_q    <= kp.ps2_key[10];
            primed_q <= 1'b1;
            sel_q    <= sel_d;
            pad1_q   <= pad1_d;
            pad2_q   <= pad2_d;
            ef3_q    <= (sel_q < 4'd10) ? pad1_q[sel_q] : 1'b0;
            ef4_q    <= (sel_q < 4'd10) ? pad2_q[sel_q] : 1'b0;
        end
    end

    assign kp.ef3       = ef3_q;
    assign kp.ef4       = ef4_q;
    assign kp.pad1_keys = pad1_q;
    assign kp.pad2_keys = pad2_q;
endmodule

// File: tb/tb_studioii_keypad.sv
// Directed bench for studioii_keypad with an expected-result queue.
// Watchdog expectations follow KEYPAD_WATCHDOG_EN with WDT_CYCLES=16.
module tb_studioii_keypad;
    logic clk;
    logic reset_n;

    studioii_keypad_if kp_if ();

    studioii_keypad #(.WDT_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [9:0] p1,
                        input logic [9:0] p2, input logic e3, input logic e4);
        exp_t e;
        e.tag = tag;
        e.v   = {p1, p2, e3, e4};
        sbq.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [21:0] obs;
        e   = sbq.pop_front();
        obs = {kp_if.pad1_keys, kp_if.pad2_keys, kp_if.ef3, kp_if.ef4};
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        kp_if.key_sel_we = 1'b0;
    endtask

    // Drive, clock one edge, then compare against the queued expectation.
    task automatic exp_step(input string tag, input logic [9:0] p1,
                            input logic [9:0] p2, input logic e3, input logic e4);
        push(tag, p1, p2, e3, e4);
        step();
        check();
    endtask

    task automatic key(input logic [7:0] code, input logic mk, input logic ext);
        kp_if.ps2_key = {~kp_if.ps2_key[10], mk, ext, code};
    endtask

    task automatic sel(input logic [3:0] s);
        kp_if.key_sel    = s;
        kp_if.key_sel_we = 1'b1;
    endtask

    initial begin
        reset_n          = 1'b0;
        kp_if.ps2_key    = 11'h400;
        kp_if.key_sel    = 4'd0;
        kp_if.key_sel_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("rst", 10'h000, 10'h000, 1'b0, 1'b0);
        check();

        reset_n = 1'b1;
        exp_step("prime", 10'h000, 10'h000, 1'b0, 1'b0);
        exp_step("prime2", 10'h000, 10'h000, 1'b0, 1'b0);

        sel(4'd3);
        exp_step("sel3", 10'h000, 10'h000, 1'b0, 1'b0);
        key(8'h26, 1'b1, 1'b0);
        exp_step("mk26", 10'h008, 10'h000, 1'b0, 1'b0);
        exp_step("ef3_on", 10'h008, 10'h000, 1'b1, 1'b0);
        key(8'h26, 1'b0, 1'b0);
        exp_step("brk26", 10'h000, 10'h000, 1'b1, 1'b0);
        exp_step("ef3_off", 10'h000, 10'h000, 1'b0, 1'b0);

        key(8'h7D, 1'b1, 1'b0);
        exp_step("mk7d", 10'h000, 10'h200, 1'b0, 1'b0);
        sel(4'd9);
        exp_step("sel9_wr", 10'h000, 10'h200, 1'b0, 1'b0);
        exp_step("ef4_on", 10'h000, 10'h200, 1'b0, 1'b1);
        sel(4'd12);
        exp_step("sel12_wr", 10'h000, 10'h200, 1'b0, 1'b1);
        exp_step("sel12", 10'h000, 10'h200, 1'b0, 1'b0);
        sel(4'd9);
        exp_step("sel9b_wr", 10'h000, 10'h200, 1'b0, 1'b0);
        exp_step("sel9_back", 10'h000, 10'h200, 1'b0, 1'b1);

        key(8'h75, 1'b1, 1'b1);
        exp_step("ext75", 10'h000, 10'h200, 1'b0, 1'b1);
        key(8'h75, 1'b1, 1'b0);
        exp_step("mk75", 10'h000, 10'h300, 1'b0, 1'b1);
        key(8'h75, 1'b1, 1'b0);
        exp_step("rep75", 10'h000, 10'h300, 1'b0, 1'b1);
        key(8'h1C, 1'b1, 1'b0);
        exp_step("unmapped", 10'h000, 10'h300, 1'b0, 1'b1);
        key(8'h45, 1'b0, 1'b0);
        exp_step("brk_rel", 10'h000, 10'h300, 1'b0, 1'b1);

        sel(4'd5);
        key(8'h2E, 1'b1, 1'b0);
        exp_step("same_edge", 10'h020, 10'h300, 1'b0, 1'b1);
        exp_step("same_ef", 10'h020, 10'h300, 1'b1, 1'b0);
        key(8'h45, 1'b1, 1'b0);
        exp_step("multi", 10'h021, 10'h300, 1'b1, 1'b0);

        key(8'h2E, 1'b0, 1'b0);
        step();
        key(8'h45, 1'b0, 1'b0);
        step();
        key(8'h7D, 1'b0, 1'b0);
        step();
        key(8'h75, 1'b0, 1'b0);
        exp_step("all_brk", 10'h000, 10'h000, 1'b0, 1'b0);

        sel(4'd1);
        key(8'h16, 1'b1, 1'b0);
        exp_step("mk16", 10'h002, 10'h000, 1'b0, 1'b0);
        repeat (14) step();
        push("idle14", 10'h002, 10'h000, 1'b1, 1'b0);
        check();
        exp_step("wdt_pre", 10'h002, 10'h000, 1'b1, 1'b0);
`ifdef KEYPAD_WATCHDOG_EN
        exp_step("wdt_clr", 10'h000, 10'h000, 1'b1, 1'b0);
        exp_step("wdt_ef3", 10'h000, 10'h000, 1'b0, 1'b0);
`else
        exp_step("wdt_clr", 10'h002, 10'h000, 1'b1, 1'b0);
        exp_step("wdt_ef3", 10'h002, 10'h000, 1'b1, 1'b0);
`endif

        #3;
        reset_n = 1'b0;
        #1;
        push("async_rst", 10'h000, 10'h000, 1'b0, 1'b0);
        check();
        key(8'h16, 1'b1, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        exp_step("reprime", 10'h000, 10'h000, 1'b0, 1'b0);
        exp_step("reprime2", 10'h000, 10'h000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
